del_var_x: RTL and testbench

Programmable-length DFF/LUT delay line with an output-valid flag. It delays a `width`-bit sample stream by a runtime-selectable number of clock-enabled cycles, from 1 to `max_length`. It replaces fixed-length delay lines where pipeline-alignment depth must change at runtime, for example when window size or kernel latency is reconfigured. The block uses a circular buffer with a write pointer rather than a full shift register, so a length change needs no re-synthesis.

---
 rtl/del_var_x_if.sv | 23 ++
 rtl/del_var_x.sv | 94 +++++++++
 tb/tb_del_var_x.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/del_var_x_if.sv
// del_var_x sample-stream bundle.
// Master drives ce/ld/len/i; slave returns o/ov.
interface del_var_x_if #(
  parameter int width = 8,
  parameter int lw    = 5
);
  logic             ce;
  logic             ld;
  logic [lw-1:0]    len;
  logic [width-1:0] i;
  logic [width-1:0] o;
  logic             ov;

  modport master (
    output ce, ld, len, i,
    input  o, ov
  );

  modport slave (
    input  ce, ld, len, i,
    output o, ov
  );
endinterface

// File: rtl/del_var_x.sv
// Runtime-programmable delay line (1..max_length ce-cycles).
// Circular buffer of max_length-1 words plus registered output.
module del_var_x #(
  parameter int width       = 8,
  parameter int max_length  = 16,
  parameter int init_length = 16
) (
  input logic        clk,
  input logic        rst,
  del_var_x_if.slave bus
);
  localparam int lw    = $clog2(max_length + 1);
  localparam int depth = max_length - 1;
  localparam int aw    = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wp;
  logic [aw-1:0]    wp_nx;
  logic [aw-1:0]    rd;
  logic [aw:0]      off;
  logic [aw:0]      wpx;
  logic [aw:0]      rdx;
  logic [lw-1:0]    len_q;
  logic [lw-1:0]    len_cl;
  logic [lw-1:0]    cnt;
  logic [lw-1:0]    cnt_nx;
  logic [width-1:0] d;
  logic [width-1:0] o_q;
  logic             ov_q;

  assign bus.o  = o_q;
  assign bus.ov = ov_q;

  // Clamp requested length into 1..max_length
  always_comb begin
    len_cl = bus.len;
    if (bus.len == '0)
      len_cl = lw'(1);
    else if (bus.len > lw'(max_length))
      len_cl = lw'(max_length);
  end

  // Read index = wp - (len_q-1) mod depth; len_q=max reads the slot about to be overwritten
  always_comb begin
    off = (aw+1)'(len_q - lw'(1));
    wpx = {1'b0, wp};
    if (wpx >= off)
      rdx = wpx - off;
    else
      rdx = wpx + (aw+1)'(depth) - off;
    rd = rdx[aw-1:0];
  end

  // Delayed sample, bypass for len_q=1; pointer and fill-count successors
  always_comb begin
    d      = (len_q == lw'(1)) ? bus.i : mem[rd];
    wp_nx  = (wp == aw'(depth - 1)) ? '0 : wp + aw'(1);
    cnt_nx = (cnt == len_q) ? cnt : cnt + lw'(1);
  end

  // Sample storage, written on every ce-cycle, never reset
  always_ff @(posedge clk) begin
    if (!rst && bus.ce)
      mem[wp] <= bus.i;
  end

  // Control state and registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      cnt   <= '0;
      len_q <= lw'(init_length);
      o_q   <= '0;
      ov_q  <= 1'b0;
    end else if (bus.ld) begin
      len_q <= len_cl;
      cnt   <= '0;
      o_q   <= '0;
      ov_q  <= 1'b0;
      if (bus.ce)
        wp <= wp_nx;
    end else if (bus.ce) begin
      wp  <= wp_nx;
      cnt <= cnt_nx;
      if (cnt_nx == len_q) begin
        o_q  <= d;
        ov_q <= 1'b1;
      end else begin
        o_q  <= '0;
        ov_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_del_var_x.sv
// Bench for del_var_x: delay-line reference model feeds a queue
// of expected {ov,o}; each test pops and compares after the edge.
module tb_del_var_x;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  del_var_x_if #(.width(8), .lw(5)) bus ();

  del_var_x #(
    .width(8),
    .max_length(16),
    .init_length(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] exp_q [$];
  logic [7:0] hist [$];
  int         m_len;
  int         m_cnt;
  logic [7:0] m_o;
  logic       m_ov;
  logic [8:0] e;

  // Drive one clock, advance reference model, queue expectation
  task automatic drive(input logic r, input logic c, input logic l,
                       input logic [4:0] ln, input logic [7:0] di);
    @(negedge clk);
    rst     = r;
    bus.ce  = c;
    bus.ld  = l;
    bus.len = ln;
    bus.i   = di;
    if (r) begin
      m_len = 16; m_cnt = 0; hist.delete(); m_o = 0; m_ov = 0;
    end else if (l) begin
      m_len = (ln == 0) ? 1 : ((ln > 16) ? 16 : int'(ln));
      m_cnt = 0; hist.delete(); m_o = 0; m_ov = 0;
    end else if (c) begin
      hist.push_back(di);
      if (hist.size() > 16) void'(hist.pop_front());
      m_cnt = (m_cnt + 1 > m_len) ? m_len : m_cnt + 1;
      if (m_cnt == m_len) begin
        m_o  = hist[hist.size() - m_len];
        m_ov = 1'b1;
      end else begin
        m_o  = 8'd0;
        m_ov = 1'b0;
      end
    end
    exp_q.push_back({m_ov, m_o});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1, 1, 1, 5'd3, 8'hAA);
    drive(1, 0, 0, 5'd0, 8'h00);
    e = exp_q.pop_front(); void'(exp_q.pop_front());
    n_cmp++;
    if (bus.ov !== 1'b0 || bus.o !== 8'd0) begin
      n_bad++;
      $display("FAIL reset: got ov=%b o=%0d, want ov=0 o=0", bus.ov, bus.o);
    end
  endtask

  task automatic test_fill;
    for (int k = 1; k <= 40; k++) begin
      drive(0, 1, 0, 5'd0, 8'(k));
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.ov, bus.o} !== e) begin
        n_bad++;
        $display("FAIL fill k=%0d: got ov=%b o=%0d, want ov=%b o=%0d",
                 k, bus.ov, bus.o, e[8], e[7:0]);
      end
      n_cmp++;
      if (k < 16 && (bus.ov !== 1'b0 || bus.o !== 8'd0)) begin
        n_bad++;
        $display("FAIL fill_early k=%0d: got ov=%b o=%0d, want 0/0", k, bus.ov, bus.o);
      end else if (k >= 16 && (bus.ov !== 1'b1 || bus.o !== 8'(k - 15))) begin
        n_bad++;
        $display("FAIL fill_late k=%0d: got ov=%b o=%0d, want 1/%0d",
                 k, bus.ov, bus.o, k - 15);
      end
    end
  endtask

  task automatic test_len1;
    drive(0, 0, 1, 5'd1, 8'd0);
    void'(exp_q.pop_front());
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 0, 5'd0, 8'(50 + 3 * k));
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.ov, bus.o} !== e || bus.o !== 8'(50 + 3 * k)) begin
        n_bad++;
        $display("FAIL len1 k=%0d: got ov=%b o=%0d, want ov=%b o=%0d",
                 k, bus.ov, bus.o, e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_ce_toggle;
    drive(0, 0, 1, 5'd4, 8'd0);
    void'(exp_q.pop_front());
    for (int k = 0; k < 24; k++) begin
      drive(0, (k % 2 == 0), 0, 5'd0, 8'(200 + k));
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.ov, bus.o} !== e) begin
        n_bad++;
        $display("FAIL ce_toggle k=%0d: got ov=%b o=%0d, want ov=%b o=%0d",
                 k, bus.ov, bus.o, e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_clamp(input logic [4:0] ln, input int exp_len);
    drive(0, 0, 1, ln, 8'd0);
    void'(exp_q.pop_front());
    for (int k = 1; k <= 24; k++) begin
      drive(0, 1, 0, 5'd0, 8'(k * 7));
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.ov, bus.o} !== e || bus.ov !== (k >= exp_len)) begin
        n_bad++;
        $display("FAIL clamp len=%0d k=%0d: got ov=%b o=%0d, want ov=%b o=%0d",
                 ln, k, bus.ov, bus.o, e[8], e[7:0]);
      end
    end
  endtask

  task automatic test_midload;
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 5'd0, 8'(90 + k));
      void'(exp_q.pop_front());
    end
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, (k == 0), 5'd3, 8'(100 + k));
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.ov, bus.o} !== e) begin
        n_bad++;
        $display("FAIL midload k=%0d: got ov=%b o=%0d, want ov=%b o=%0d",
                 k, bus.ov, bus.o, e[8], e[7:0]);
      end
      n_cmp++;
      if (k == 3 && (bus.ov !== 1'b1 || bus.o !== 8'd101)) begin
        n_bad++;
        $display("FAIL midload_first: got ov=%b o=%0d, want 1/101", bus.ov, bus.o);
      end
    end
  endtask

  task automatic test_rst_ld;
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 0, 5'd0, 8'(30 + k));
      void'(exp_q.pop_front());
    end
    for (int k = 0; k <= 20; k++) begin
      drive((k == 0), 1, (k == 0), 5'd3, 8'(150 + k));
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.ov, bus.o} !== e || bus.ov !== (k >= 16)) begin
        n_bad++;
        $display("FAIL rst_ld k=%0d: got ov=%b o=%0d, want ov=%b o=%0d",
                 k, bus.ov, bus.o, e[8], e[7:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.ce = 1'b0;
    bus.ld = 1'b0;
    bus.len = '0;
    bus.i = '0;
    m_len = 16; m_cnt = 0; m_o = 0; m_ov = 0;
    test_reset();
    test_fill();
    test_len1();
    test_ce_toggle();
    test_clamp(5'd0, 1);
    test_clamp(5'd20, 16);
    test_midload();
    test_rst_ld();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
